// File: rtl/ret_addr_stack_if.sv
// Bus between the retire stage and the return-address stack.
// Optional error flags exist only when RET_ADDR_STACK_ERR_EN is defined.
interface ret_addr_stack_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic           instr_vld;
    logic           stall;
    logic [15:0]    instr;
    logic [AW-1:0]  pc;
    logic [AW-1:0]  ret_addr;
    logic           empty;
    logic           full;
    logic [PTR_W:0] count;
`ifdef RET_ADDR_STACK_ERR_EN
    logic           ovf;
    logic           unf;
    logic           err_clr;
`endif

    // Retire stage side: presents retiring instructions, consumes ret_addr.
    modport master (
        output instr_vld, stall, instr, pc,
`ifdef RET_ADDR_STACK_ERR_EN
        output err_clr,
        input  ovf, unf,
`endif
        input  ret_addr, empty, full, count
    );

    // Stack side.
    modport slave (
        input  instr_vld, stall, instr, pc,
`ifdef RET_ADDR_STACK_ERR_EN
        input  err_clr,
        output ovf, unf,
`endif
        output ret_addr, empty, full, count
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack: CALL pushes pc+1, RET pops; top of stack
// is presented combinationally on ret_addr for the writeback mux.
// Optional sticky overflow/underflow flags: define RET_ADDR_STACK_ERR_EN.
// Opcode values come from opcode.h when it is included first; otherwise the
// local defaults below are used.
`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module ret_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input logic              clk,
    input logic              rst_n,
    ret_addr_stack_if.slave  bus
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [AW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, top_idx;
    logic [PTR_W:0]   count_q, count_d;
    logic [3:0]       op;
    logic             act, push, pop, is_empty, is_full;

    assign op       = bus.instr[15:12];
    assign act      = bus.instr_vld & ~bus.stall;
    assign push     = act & (op == `CALL);
    assign pop      = act & (op == `RET);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_MAX);
    assign top_idx  = sp_q - PTR_W'(1);

    // Next pointer/count; a full push wraps and overwrites the oldest entry.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (push) begin
            sp_d = sp_q + PTR_W'(1);
            if (!is_full) count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !is_empty) begin
            sp_d    = top_idx;
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; link address wraps naturally at AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[sp_q] <= bus.pc + AW'(1);
        end
    end

    assign bus.ret_addr = is_empty ? '0 : mem_q[top_idx];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.count    = count_q;

`ifdef RET_ADDR_STACK_ERR_EN
    logic ovf_q, unf_q;

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && is_full)        ovf_q <= 1'b1;
            else if (bus.err_clr)       ovf_q <= 1'b0;
            if (pop && is_empty)        unf_q <= 1'b1;
            else if (bus.err_clr)       unf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
`endif
endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed scenarios plus randomized traffic,
// checked against a queue-based model of a bounded return stack.
module tb_ret_addr_stack;
    localparam int         DEPTH   = 8;
    localparam int         AW      = 16;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ret_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus();
    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] q[$];
    bit          m_ovf, m_unf;
    bit          tb_clr;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [15:0] exp_top;
        exp_top = (q.size() != 0) ? q[$] : 16'h0000;
        chk({tag, ".ret_addr"}, 32'(bus.ret_addr), 32'(exp_top));
        chk({tag, ".count"},    32'(bus.count),    32'(q.size()));
        chk({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
        chk({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
`ifdef RET_ADDR_STACK_ERR_EN
        chk({tag, ".ovf"},      32'(bus.ovf),      32'(m_ovf));
        chk({tag, ".unf"},      32'(bus.unf),      32'(m_unf));
`endif
    endtask

    // One retire slot: drive, check same-cycle view, clock, update model, check.
    task automatic step(input logic vld, input logic stl, input logic [3:0] op,
                        input logic [15:0] p, input string tag);
        bit act;
        bus.instr_vld = vld;
        bus.stall     = stl;
        bus.instr     = {op, 12'($urandom)};
        bus.pc        = p;
`ifdef RET_ADDR_STACK_ERR_EN
        bus.err_clr   = tb_clr;
`endif
        #2;
        check_state({tag, ".pre"});
        @(posedge clk);
        act = vld && !stl;
        if (tb_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (act && op == OP_CALL) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            q.push_back(p + 16'd1);
        end else if (act && op == OP_RET) begin
            if (q.size() == 0) m_unf = 1'b1;
            else void'(q.pop_back());
        end
        #1;
        bus.instr_vld = 1'b0;
        bus.stall     = 1'b0;
        tb_clr        = 1'b0;
`ifdef RET_ADDR_STACK_ERR_EN
        bus.err_clr   = 1'b0;
`endif
        check_state({tag, ".post"});
    endtask

    initial begin
        logic [3:0] rop;
        rst_n = 1'b0;
        tb_clr = 1'b0;
        bus.instr_vld = 1'b0;
        bus.stall = 1'b0;
        bus.instr = '0;
        bus.pc = '0;
`ifdef RET_ADDR_STACK_ERR_EN
        bus.err_clr = 1'b0;
`endif
        #1;
        check_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 16'h0000, "idle");

        step(1'b1, 1'b0, OP_CALL, 16'h0040, "call40");
        step(1'b1, 1'b0, OP_RET,  16'h0050, "ret40");

        step(1'b1, 1'b0, OP_CALL, 16'h0010, "nest.c1");
        step(1'b1, 1'b0, OP_CALL, 16'h0020, "nest.c2");
        step(1'b1, 1'b0, OP_CALL, 16'h0030, "nest.c3");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, OP_RET, 16'h0099, "nest.ret");

        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, OP_CALL, 16'h0100 + 16'(i), "ovf.call");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, OP_RET, 16'h0200, "ovf.ret");

        step(1'b1, 1'b0, OP_RET, 16'h0300, "unf.ret");
        tb_clr = 1'b1;
        step(1'b0, 1'b0, 4'h0, 16'h0000, "errclr");

        step(1'b1, 1'b1, OP_CALL, 16'h0400, "stall.call");
        step(1'b0, 1'b0, OP_CALL, 16'h0410, "novld.call");
        step(1'b1, 1'b0, OP_CALL, 16'hFFFF, "wrap.call");
        step(1'b1, 1'b0, OP_RET,  16'h0000, "wrap.ret");

        // Reset mid-operation with a CALL retiring across the reset edge.
        step(1'b1, 1'b0, OP_CALL, 16'h0500, "rst.c1");
        step(1'b1, 1'b0, OP_CALL, 16'h0510, "rst.c2");
        bus.instr_vld = 1'b1;
        bus.instr     = {OP_CALL, 12'h000};
        bus.pc        = 16'h0520;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state("rst.async");
        @(posedge clk);
        #1;
        check_state("rst.held");
        bus.instr_vld = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, 16'h0000, "rst.after");

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rop = OP_CALL;
                4, 5, 6:    rop = OP_RET;
                default:    rop = 4'($urandom_range(0, 11));
            endcase
            tb_clr = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, rop,
                 16'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
